seq_divider: RTL

//  Iterative restoring divider for the datapath's DIV instruction. Accepts two signed

---
 rtl/seq_divider_pkg.sv | 14 +
 rtl/seq_divider_step.sv | 27 ++
 rtl/seq_divider.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and sizing for the iterative signed divider.
package seq_divider_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int STEP_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_divider_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder, try subtracting the divisor, and keep the difference if it did
// not borrow.
module seq_divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    // The partial remainder is always below |divisor| <= 2^(W-1), so its top
    // bit is zero and the W+1 bit shifted value equals the W-bit one.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Trial subtract; bit WIDTH of the difference is the borrow.
    always_comb begin
        shifted  = {rem, q_msb};
        trial    = shifted - {1'b0, dvsr};
        q_bit    = ~trial[WIDTH];
        rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed restoring divider: one quotient bit per clock, magnitudes
// divided unsigned, signs applied in a final fixup cycle.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] dvsr_reg;
    logic [CW-1:0]    cnt_reg;
    logic             sign_dd_reg;
    logic             sign_dv_reg;
    logic             zero_reg;

    logic             load;
    logic             step;
    logic             fix;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] dd_mag;
    logic [WIDTH-1:0] dv_mag;

    assign dd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign dv_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

    seq_divider_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_reg),
        .q_msb    (q_reg[WIDTH-1]),
        .dvsr     (dvsr_reg),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and datapath enables. A zero divisor skips the
    // iterations and goes straight to the fixup cycle, so done still arrives
    // one edge after the accept.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        fix        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = (divisor == '0) ? FIX : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt_reg == CW'(1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                fix        = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = (divisor == '0) ? FIX : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, restoring iterations and sign fixup of the results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_reg     <= '0;
            q_reg       <= '0;
            dvsr_reg    <= '0;
            cnt_reg     <= '0;
            sign_dd_reg <= 1'b0;
            sign_dv_reg <= 1'b0;
            zero_reg    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_zero    <= 1'b0;
        end else if (load) begin
            rem_reg     <= '0;
            q_reg       <= dd_mag;
            dvsr_reg    <= dv_mag;
            cnt_reg     <= CW'(WIDTH);
            sign_dd_reg <= dividend[WIDTH-1];
            sign_dv_reg <= divisor[WIDTH-1];
            zero_reg    <= (divisor == '0);
            div_zero    <= 1'b0;
        end else if (step) begin
            rem_reg <= rem_next;
            q_reg   <= {q_reg[WIDTH-2:0], q_bit};
            cnt_reg <= cnt_reg - CW'(1);
        end else if (fix) begin
            if (zero_reg) begin
                // q_reg still holds |dividend|; re-apply its sign.
                quotient  <= '1;
                remainder <= sign_dd_reg ? -q_reg : q_reg;
                div_zero  <= 1'b1;
            end else begin
                quotient  <= (sign_dd_reg ^ sign_dv_reg) ? -q_reg : q_reg;
                remainder <= sign_dd_reg ? -rem_reg : rem_reg;
            end
        end
    end

endmodule
